mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that sits directly downstream of the single-cycle core's store port, beside the data memory. It snoops `MemWrite`/`DataAdr`/`WriteData`, captures byte writes to its TX register into a small FIFO, and serializes them as 8N1 frames on `tx`. A status word is exposed for the core's load path, and a sticky overflow flag records dropped bytes.

---
 rtl/riscv_mmio_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/mmio_uart_tx.sv | 156 +++++++++++++++
 tb/tb_mmio_uart_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mmio_pkg.sv
// Shared definitions for the memory-mapped peripherals on the single-cycle core's store port:
// default register addresses, status bit positions and the UART transmitter state encoding.
package riscv_mmio_pkg;

  localparam logic [31:0] UART_TX_ADDR   = 32'h0000_0100;
  localparam logic [31:0] UART_STAT_ADDR = 32'h0000_0104;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                              input logic empty, input logic ovf);
    logic [31:0] s;
    s             = '0;
    s[STAT_BUSY]  = busy;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[STAT_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; otherwise it is ignored and the caller decides what to flag.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the core's store port. Byte writes to the TX
// register are queued in a FIFO and serialized on tx; a status word feeds the load path.
module mmio_uart_tx
  import riscv_mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = UART_TX_ADDR,
  parameter logic [31:0] STAT_ADDR    = UART_STAT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] StatusData,
  output logic        tx,
  output logic        tx_busy,
  output logic        fifo_full,
  output logic        overflow
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;

  logic             push_req, clr_req, drop;
  logic             fifo_pop, fifo_empty, baud_tick;
  logic [7:0]       fifo_dout;
  logic             unused_wdata;

  assign push_req     = MemWrite && (DataAdr == TX_ADDR);
  assign clr_req      = MemWrite && (DataAdr == STAT_ADDR) && WriteData[0];
  assign unused_wdata = ^WriteData[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push_req),
    .push_data (WriteData[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A full FIFO still takes the push when the transmitter frees a slot in the same cycle.
  assign drop = push_req && fifo_full && !fifo_pop;

  always_comb begin
    ovf_d = ovf_q;
    if (clr_req) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  assign baud_tick = (cnt_q == CNT_LAST);

  // Next-state logic: FSM, baud counter, bit index, shift register and FIFO pop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      UART_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = UART_START;
        end
      end
      UART_START: begin
        if (baud_tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = UART_DATA;
        end
      end
      UART_DATA: begin
        if (baud_tick) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      UART_STOP: begin
        if (baud_tick) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = UART_START;
          end else begin
            state_d = UART_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = UART_IDLE;
      end
    endcase
  end

  // Line level is derived from the next state so tx is a clean register output.
  always_comb begin
    tx_busy = (state_q != UART_IDLE);
    case (state_d)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = shift_d[0];
      default:    tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx         = tx_q;
  assign overflow   = ovf_q;
  assign StatusData = pack_status(tx_busy, fifo_full, fifo_empty, ovf_q);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a queue-based model predicts the serial line and status every cycle,
// while directed scenarios pin the model with hand-computed frame bits and frame lengths.
module tb_mmio_uart_tx;
  import riscv_mmio_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] StatusData;
  logic        tx, tx_busy, fifo_full, overflow;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .TX_ADDR      (UART_TX_ADDR),
    .STAT_ADDR    (UART_STAT_ADDR)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .StatusData (StatusData),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Line level during cycle i of a frame carrying byte b (start, 8 data LSB first, stop).
  function automatic bit frame_bit(input logic [7:0] b, input int i);
    int slot;
    slot = i / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  // Model: pending bytes, plus the remaining line levels of the frame on the wire.
  logic [7:0] m_fifo[$];
  bit         m_stream[$];
  bit         m_ovf;
  int         m_drops;

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] b;
    logic       wr_tx, wr_st, dropped;
    if (!rst_n) begin
      m_fifo.delete();
      m_stream.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      if (m_stream.size() > 0) void'(m_stream.pop_front());
      if (m_stream.size() == 0 && m_fifo.size() > 0) begin
        b = m_fifo.pop_front();
        for (int i = 0; i < FRAME; i++) m_stream.push_back(frame_bit(b, i));
      end
      wr_tx   = MemWrite && (DataAdr == UART_TX_ADDR);
      wr_st   = MemWrite && (DataAdr == UART_STAT_ADDR);
      dropped = 1'b0;
      if (wr_tx) begin
        if (m_fifo.size() < DEPTH) begin
          m_fifo.push_back(WriteData[7:0]);
        end else begin
          dropped = 1'b1;
          m_ovf   = 1'b1;
          m_drops++;
        end
      end
      if (wr_st && WriteData[0] && !dropped) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic e_tx, e_busy, e_full, e_empty;
    if (rst_n && cmp_en) begin
      e_tx    = (m_stream.size() == 0) ? 1'b1 : m_stream[0];
      e_busy  = (m_stream.size() != 0);
      e_full  = (m_fifo.size() == DEPTH);
      e_empty = (m_fifo.size() == 0);
      check("tx", tx, e_tx);
      check("tx_busy", tx_busy, e_busy);
      check("fifo_full", fifo_full, e_full);
      check("overflow", overflow, m_ovf);
      check("status", StatusData, {28'b0, m_ovf, e_empty, e_full, e_busy});
    end
  end

  int run_len = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else if (tx_busy) begin
      run_len++;
    end else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int bound);
    int k;
    k = 0;
    while ((m_stream.size() != 0 || m_fifo.size() != 0) && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= bound) check("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
    #1;
  endtask

  // Waits on negedges until the current frame has exactly `left` line cycles remaining.
  task automatic wait_stream(input int left, input int need_full, input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(m_stream.size() == left && (need_full == 0 || m_fifo.size() == DEPTH)) && k < 200);
    if (k >= 200) check(name, 32'd1, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp_seq;
    int         d0, lows, sel;

    #2 rst_n = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_status", StatusData, 32'h4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk);
    #1;

    // Single byte 0xA5: line levels per bit period in time order.
    exp_seq = 10'b11_0100_1010;
    bus_write(UART_TX_ADDR, 32'h0000_00A5);
    @(negedge clk);
    check("a5_before_fall", tx, 1);
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      if (j % CPB == CPB / 2) check($sformatf("a5_bit%0d", j / CPB), tx, exp_seq[j / CPB]);
    end
    wait_drain(200);
    check("a5_busy_cycles", last_run, FRAME);

    // Burst of three bytes on consecutive cycles.
    bus_write(UART_TX_ADDR, 32'h01);
    bus_write(UART_TX_ADDR, 32'h02);
    bus_write(UART_TX_ADDR, 32'h03);
    wait_drain(400);
    check("burst_busy_cycles", last_run, 3 * FRAME);

    // Ten writes from IDLE: one popped, eight buffered, one dropped.
    d0 = m_drops;
    for (int i = 0; i < 10; i++) bus_write(UART_TX_ADDR, 32'h10 + i);
    check("ovf_flag", overflow, 1);
    check("ovf_status_bit", StatusData[3], 1);
    check("ovf_full", fifo_full, 1);
    check("ovf_drop_count", m_drops - d0, 1);
    bus_write(UART_STAT_ADDR, 32'h1);
    check("ovf_cleared", overflow, 0);

    // Write into a full FIFO exactly on the STOP->START pop edge.
    wait_stream(1, 1, "fullpop_timeout");
    bus_write(UART_TX_ADDR, 32'h5A);
    check("fullpop_no_ovf", overflow, 0);
    check("fullpop_still_full", fifo_full, 1);
    wait_drain(1000);

    // Reset asserted during data bit 3 of a frame with another byte queued.
    bus_write(UART_TX_ADDR, 32'h3C);
    bus_write(UART_TX_ADDR, 32'hC3);
    wait_stream(FRAME - 4 * CPB - 1, 0, "midreset_timeout");
    #2 rst_n = 1'b0;
    #1;
    check("midreset_tx", tx, 1);
    check("midreset_status", StatusData, 32'h4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    check("midreset_no_frames", lows, 0);
    @(posedge clk);
    #1;

    // Writes to unmapped addresses.
    bus_write(32'h0000_0108, 32'hFF);
    bus_write(32'h0000_0000, 32'h55);
    idle_cycles(5);
    check("decode_status", StatusData, 32'h4);
    check("decode_tx", tx, 1);

    // Dense random traffic: overflow and clear interleave with transmission.
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 31);
      if (sel < 3)       bus_write(UART_TX_ADDR, $urandom());
      else if (sel == 3) bus_write(UART_STAT_ADDR, $urandom());
      else if (sel == 4) bus_write($urandom() & 32'h0000_01FC, $urandom());
      else               idle_cycles(1);
    end
    wait_drain(1000);

    // Sparse random traffic: FIFO drains to idle between bytes.
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 63);
      if (sel == 0)      bus_write(UART_TX_ADDR, $urandom());
      else if (sel == 1) bus_write(UART_STAT_ADDR, $urandom());
      else if (sel == 2) bus_write($urandom(), $urandom());
      else               idle_cycles(1);
    end
    wait_drain(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
